conv_control_gen: RTL

Parametrised successor of the single-layer convolution controller. It sequences one convolution layer: primes the feature/weight M9K read pipeline, walks the per-pixel MAC cycle count, time-multiplexes any number of input-feature bank groups onto the IFMAP_PAR-wide multiplier inputs, and reports start/done. It sits between the feature/weight memories plus address generators and the DSP multiply-accumulate array. Unlike the fixed version it has a go/busy/done handshake, a stall input, and an explicit drain phase.

---
 rtl/conv_control_gen_pkg.sv | 35 +++
 rtl/conv_control_gen_bank_group_mux.sv | 44 ++++
 rtl/conv_control_gen.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/conv_control_gen_pkg.sv
// Shared definitions for the convolution layer controller.
// Holds the controller state encoding and the constant functions used to
// derive group counts, per-pixel cycle counts and counter widths from the
// top-level parameters.
package conv_control_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bank groups per pixel.
  function automatic int num_groups(input int num_mem, input int par);
    return num_mem / par;
  endfunction

  // MAC cycles per output pixel.
  function automatic int one_pixel_cycles(input int cpg, input int num_mem, input int par);
    return cpg * (num_mem / par);
  endfunction

  // Output pixels per layer.
  function automatic int total_pix(input int side, input int num_onemult);
    return side * side * num_onemult;
  endfunction

endpackage

// File: rtl/conv_control_gen_bank_group_mux.sv
// Combinational bank-group selector.
// Presents IFMAP_PAR consecutive banks (group sel) out of INPUT_NUM_MEM
// packed banks; when enable is low the whole bus carries FILL_VALUE,
// zero-extended.
// Ports:
//   enable    - 1: pass selected group, 0: drive FILL_VALUE
//   sel       - active bank group
//   bank_all  - all banks, bank i at [i*DATA_WIDTH +: DATA_WIDTH]
//   group_all - selected group, slot k = bank[sel*IFMAP_PAR+k]
module bank_group_mux
  import conv_control_gen_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int INPUT_NUM_MEM = 8,
  parameter int IFMAP_PAR     = 4,
  parameter int FILL_VALUE    = 1,
  parameter int SEL_W         = 1
) (
  input  logic                              enable,
  input  logic [SEL_W-1:0]                  sel,
  input  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] bank_all,
  output logic [DATA_WIDTH*IFMAP_PAR-1:0]   group_all
);

  localparam int GROUP_W    = DATA_WIDTH * IFMAP_PAR;
  localparam int NUM_GROUPS = num_groups(INPUT_NUM_MEM, IFMAP_PAR);

  logic [GROUP_W-1:0] group_s;

  // Pick the group whose index matches sel; groups are contiguous slices.
  always_comb begin
    group_s = GROUP_W'(FILL_VALUE);
    if (enable) begin
      for (int g = 0; g < NUM_GROUPS; g++) begin
        group_s = (sel == SEL_W'(g)) ? bank_all[g*GROUP_W +: GROUP_W] : group_s;
      end
    end else begin
      group_s = GROUP_W'(FILL_VALUE);
    end
  end

  assign group_all = group_s;

endmodule

// File: rtl/conv_control_gen.sv
// Convolution layer controller.
// Sequences one layer: PRIME fills the memory/multiplier pipeline, RUN walks
// the per-pixel MAC cycles while rotating bank groups onto the multiplier
// inputs, DRAIN flushes the pipeline, DONE holds conv_done until a new go.
// Ports:
//   clock, reset_n                 - clock, asynchronous active-low reset
//   go, stall                      - start request, RUN freeze
//   in_feature_q_{a,b}_all         - packed bank read data
//   in_feature_q_{a,b}_mux_all     - selected bank group (FILL_VALUE outside RUN)
//   *_rden_*, *_wren_*             - memory enables (writes never used)
//   enable_addrger/weightaddrger   - address generator enables
//   enable_mult, clear_mult, accum_sload - MAC array controls
//   count_sload, group_sel, pixel_count  - progress counters
//   busy, start, conv_done         - status
module conv_control_gen
  import conv_control_gen_pkg::*;
#(
  parameter int DATA_WIDTH        = 16,
  parameter int INPUT_NUM_MEM     = 8,
  parameter int IFMAP_PAR         = 4,
  parameter int CYCLES_PER_GROUP  = 9,
  parameter int OUT_FEATURE_WIDTH = 8,
  parameter int NUM_ONEMULT       = 2,
  parameter int PIPE_LAT          = 4,
  parameter int FILL_VALUE        = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic go,
  input  logic stall,
  input  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] in_feature_q_a_all,
  input  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] in_feature_q_b_all,
  output logic [DATA_WIDTH*IFMAP_PAR-1:0] in_feature_q_a_mux_all,
  output logic [DATA_WIDTH*IFMAP_PAR-1:0] in_feature_q_b_mux_all,
  output logic in_feature_rden_a,
  output logic in_feature_rden_b,
  output logic in_feature_wren_a,
  output logic in_feature_wren_b,
  output logic weight_rden_a,
  output logic weight_rden_b,
  output logic weight_wren_a,
  output logic weight_wren_b,
  output logic enable_addrger,
  output logic enable_weightaddrger,
  output logic enable_mult,
  output logic clear_mult,
  output logic accum_sload,
  output logic [width_of(one_pixel_cycles(CYCLES_PER_GROUP, INPUT_NUM_MEM, IFMAP_PAR))-1:0] count_sload,
  output logic [width_of(num_groups(INPUT_NUM_MEM, IFMAP_PAR))-1:0] group_sel,
  output logic [width_of(total_pix(OUT_FEATURE_WIDTH, NUM_ONEMULT)+1)-1:0] pixel_count,
  output logic busy,
  output logic start,
  output logic conv_done
);

  localparam int NUM_GROUPS          = num_groups(INPUT_NUM_MEM, IFMAP_PAR);
  localparam int NUM_ONE_PIXEL_CYCLE = one_pixel_cycles(CYCLES_PER_GROUP, INPUT_NUM_MEM, IFMAP_PAR);
  localparam int TOTAL_PIX           = total_pix(OUT_FEATURE_WIDTH, NUM_ONEMULT);
  localparam int CNT_W               = width_of(NUM_ONE_PIXEL_CYCLE);
  localparam int GRP_W               = width_of(NUM_GROUPS);
  localparam int PIX_W               = width_of(TOTAL_PIX + 1);
  localparam int SUB_W               = width_of(CYCLES_PER_GROUP);
  localparam int PH_W                = width_of(PIPE_LAT);

  state_t             state_r;
  logic [PH_W-1:0]    phase_r;
  logic [SUB_W-1:0]   sub_r;
  logic [CNT_W-1:0]   count_r;
  logic [GRP_W-1:0]   group_r;
  logic [PIX_W-1:0]   pix_r;
  logic               busy_r;
  logic               done_r;
  logic               rden_r;
  logic               addr_en_r;
  logic               mult_en_r;
  logic               clear_r;
  logic [PIPE_LAT-1:0] start_sr_r;
  logic               start_r;

  logic               run_s;
  logic               stall_run_s;
  logic               wrap_s;
  logic               sub_wrap_s;
  logic               first_pix_s;
  logic [PIX_W-1:0]   pix_next_s;

  // Decode of the current RUN step: pixel wrap, group step, first-pixel event.
  always_comb begin
    run_s       = (state_r == ST_RUN);
    stall_run_s = run_s & stall;
    wrap_s      = (count_r == CNT_W'(NUM_ONE_PIXEL_CYCLE - 1));
    sub_wrap_s  = (sub_r == SUB_W'(CYCLES_PER_GROUP - 1));
    pix_next_s  = pix_r + PIX_W'(1);
    first_pix_s = run_s & ~stall & wrap_s & (pix_r == '0);
  end

  // Layer sequencer with registered control outputs set for the state being entered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      phase_r   <= '0;
      sub_r     <= '0;
      count_r   <= '0;
      group_r   <= '0;
      pix_r     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      rden_r    <= 1'b0;
      addr_en_r <= 1'b0;
      mult_en_r <= 1'b0;
      clear_r   <= 1'b0;
    end else begin
      clear_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (go) begin
            state_r   <= ST_PRIME;
            phase_r   <= '0;
            sub_r     <= '0;
            count_r   <= '0;
            group_r   <= '0;
            pix_r     <= '0;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            rden_r    <= 1'b1;
            addr_en_r <= 1'b1;
            mult_en_r <= 1'b1;
            clear_r   <= 1'b1;
          end
        end
        ST_PRIME: begin
          if (phase_r == PH_W'(PIPE_LAT - 1)) begin
            state_r <= ST_RUN;
            phase_r <= '0;
          end else begin
            phase_r <= phase_r + PH_W'(1);
          end
        end
        ST_RUN: begin
          if (!stall) begin
            if (wrap_s) begin
              count_r <= '0;
              sub_r   <= '0;
              group_r <= '0;
              pix_r   <= pix_next_s;
              if (pix_next_s == PIX_W'(TOTAL_PIX)) begin
                state_r   <= ST_DRAIN;
                phase_r   <= '0;
                rden_r    <= 1'b0;
                addr_en_r <= 1'b0;
              end
            end else begin
              count_r <= count_r + CNT_W'(1);
              if (sub_wrap_s) begin
                sub_r   <= '0;
                group_r <= group_r + GRP_W'(1);
              end else begin
                sub_r <= sub_r + SUB_W'(1);
              end
            end
          end
        end
        ST_DRAIN: begin
          if (phase_r == PH_W'(PIPE_LAT - 1)) begin
            state_r   <= ST_DONE;
            phase_r   <= '0;
            busy_r    <= 1'b0;
            mult_en_r <= 1'b0;
            done_r    <= 1'b1;
          end else begin
            phase_r <= phase_r + PH_W'(1);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          rden_r    <= 1'b0;
          addr_en_r <= 1'b0;
          mult_en_r <= 1'b0;
        end
      endcase
    end
  end

  // Delay line that turns the first completed pixel into the start pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      start_sr_r <= '0;
      start_r    <= 1'b0;
    end else begin
      start_sr_r[0] <= first_pix_s;
      for (int i = 1; i < PIPE_LAT; i++) begin
        start_sr_r[i] <= start_sr_r[i-1];
      end
      start_r <= start_sr_r[PIPE_LAT-1];
    end
  end

  // A stalled RUN cycle must freeze the MAC array and address generators at once.
  assign enable_mult          = mult_en_r & ~stall_run_s;
  assign enable_addrger       = addr_en_r & ~stall_run_s;
  assign enable_weightaddrger = addr_en_r & ~stall_run_s;
  assign accum_sload          = run_s & (count_r == '0) & ~stall;

  assign in_feature_rden_a = rden_r;
  assign in_feature_rden_b = rden_r;
  assign weight_rden_a     = rden_r;
  assign weight_rden_b     = rden_r;
  assign in_feature_wren_a = 1'b0;
  assign in_feature_wren_b = 1'b0;
  assign weight_wren_a     = 1'b0;
  assign weight_wren_b     = 1'b0;

  assign clear_mult  = clear_r;
  assign count_sload = count_r;
  assign group_sel   = group_r;
  assign pixel_count = pix_r;
  assign busy        = busy_r;
  assign start       = start_r;
  assign conv_done   = done_r;

  bank_group_mux #(
    .DATA_WIDTH(DATA_WIDTH), .INPUT_NUM_MEM(INPUT_NUM_MEM), .IFMAP_PAR(IFMAP_PAR),
    .FILL_VALUE(FILL_VALUE), .SEL_W(GRP_W)
  ) u_mux_a (
    .enable(run_s), .sel(group_r), .bank_all(in_feature_q_a_all), .group_all(in_feature_q_a_mux_all)
  );

  bank_group_mux #(
    .DATA_WIDTH(DATA_WIDTH), .INPUT_NUM_MEM(INPUT_NUM_MEM), .IFMAP_PAR(IFMAP_PAR),
    .FILL_VALUE(FILL_VALUE), .SEL_W(GRP_W)
  ) u_mux_b (
    .enable(run_s), .sel(group_r), .bank_all(in_feature_q_b_all), .group_all(in_feature_q_b_mux_all)
  );

endmodule
